// File: rtl/bp_me_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_pkg
//  Purpose  : BedRock LCE request header layout, arbiter state encoding and
//             message-shape helpers shared by the LCE request arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int dword_width_gp = 64;

    typedef enum logic [3:0] {
        e_bedrock_req_rd_miss = 4'd0,
        e_bedrock_req_wr_miss = 4'd1,
        e_bedrock_req_uc_rd   = 4'd2,
        e_bedrock_req_uc_wr   = 4'd3
    } bp_bedrock_req_type_e;

    typedef struct packed {
        logic [7:0]           payload;
        logic [2:0]           size;
        logic [39:0]          addr;
        bp_bedrock_req_type_e msg_type;
    } bp_bedrock_lce_req_msg_header_s;

    localparam int lce_req_msg_header_width_lp = $bits(bp_bedrock_lce_req_msg_header_s);

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_hdr  = 2'd1,
        e_data = 2'd2
    } arb_state_e;

    // Only one processor configuration exists today; new ones add a case arm.
    function automatic int cfg_header_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return lce_req_msg_header_width_lp;
            default:          return lce_req_msg_header_width_lp;
        endcase
    endfunction

    function automatic logic bp_lce_req_has_data(bp_bedrock_lce_req_msg_header_s hdr);
        return hdr.msg_type == e_bedrock_req_uc_wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_rr_pick
//  Purpose  : Combinational round-robin pick: first valid requester at or
//             after the pointer, reported as one-hot and as an index.
//  Revision : 1.0  initial release
// ============================================================================
module bp_me_rr_pick #(
    parameter  int num_req_p     = 2,
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic [num_req_p-1:0]     valid,
    input  logic [lg_num_req_lp-1:0] ptr,
    output logic [num_req_p-1:0]     one_hot,
    output logic [lg_num_req_lp-1:0] index,
    output logic                     found
);

    logic [lg_num_req_lp-1:0] cand;

    // Walk from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        one_hot = '0;
        index   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = num_req_p - 1; off >= 0; off--) begin
            cand = lg_num_req_lp'((int'(ptr) + off) % num_req_p);
            if (valid[cand]) begin
                one_hot       = '0;
                one_hot[cand] = 1'b1;
                index         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_me_lce_req_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_lce_req_arb
//  Purpose  : Round-robin share of one LCE request link among several burst
//             LCE request sources; grant is held for a whole message.
//  Revision : 1.0  initial release
// ============================================================================
module bp_me_lce_req_arb
    import bp_me_pkg::*;
#(
    parameter  bp_params_e bp_params_p = e_bp_default_cfg,
    parameter  int         num_req_p   = 2,
    localparam int         hdr_w       = cfg_header_width(bp_params_p),
    localparam int         data_w      = dword_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [num_req_p*hdr_w-1:0]  req_header_i,
    input  logic [num_req_p-1:0]        req_header_v_i,
    output logic [num_req_p-1:0]        req_header_ready_and_o,
    input  logic [num_req_p*data_w-1:0] req_data_i,
    input  logic [num_req_p-1:0]        req_data_v_i,
    output logic [num_req_p-1:0]        req_data_ready_and_o,
    input  logic [num_req_p-1:0]        req_last_i,

    output logic [hdr_w-1:0]            lce_req_header_o,
    output logic                        lce_req_header_v_o,
    input  logic                        lce_req_header_ready_and_i,
    output logic [data_w-1:0]           lce_req_data_o,
    output logic                        lce_req_data_v_o,
    input  logic                        lce_req_data_ready_and_i,
    output logic                        lce_req_last_o,

    output logic [num_req_p-1:0]        grant_o
);

    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    arb_state_e               state;
    logic [lg_num_req_lp-1:0] grant_r;
    logic [lg_num_req_lp-1:0] rr_ptr;

    logic [num_req_p-1:0]     pick_one_hot;
    logic [lg_num_req_lp-1:0] pick_idx;
    logic                     pick_found;

    logic [lg_num_req_lp-1:0] owner;
    logic [num_req_p-1:0]     owner_one_hot;
    logic                     active;
    logic                     hdr_phase;
    logic                     data_phase;
    logic                     owner_has_data;
    logic                     header_hs;
    logic                     data_hs;
    logic                     msg_done;
    logic [lg_num_req_lp-1:0] next_ptr;

    bp_bedrock_lce_req_msg_header_s owner_hdr;

    bp_me_rr_pick #(
        .num_req_p (num_req_p)
    ) rr_pick (
        .valid   (req_header_v_i),
        .ptr     (rr_ptr),
        .one_hot (pick_one_hot),
        .index   (pick_idx),
        .found   (pick_found)
    );

    // Reset gates every output combinationally so an abandoned message
    // disappears in the same cycle reset is asserted.
    always_comb begin
        owner         = grant_r;
        owner_one_hot = '0;
        active        = 1'b0;
        if (reset_n_i) begin
            if (state == e_idle) begin
                owner         = pick_idx;
                owner_one_hot = pick_one_hot;
                active        = pick_found;
            end else begin
                owner_one_hot[grant_r] = 1'b1;
                active                 = 1'b1;
            end
        end
    end

    assign owner_hdr      = bp_bedrock_lce_req_msg_header_s'(req_header_i[owner*hdr_w +: hdr_w]);
    assign owner_has_data = bp_lce_req_has_data(owner_hdr);

    assign hdr_phase  = active & (state != e_data);
    assign header_hs  = lce_req_header_v_o & lce_req_header_ready_and_i;
    // A data beat may only ride along with, or follow, its own header.
    assign data_phase = (active & (state == e_data)) | (header_hs & owner_has_data);
    assign data_hs    = lce_req_data_v_o & lce_req_data_ready_and_i;
    assign msg_done   = (header_hs & ~owner_has_data) | (data_hs & req_last_i[owner]);
    assign next_ptr   = (owner == lg_num_req_lp'(num_req_p - 1)) ? '0 : owner + 1'b1;

    assign lce_req_header_o   = req_header_i[owner*hdr_w +: hdr_w];
    assign lce_req_header_v_o = hdr_phase & req_header_v_i[owner];
    assign lce_req_data_o     = req_data_i[owner*data_w +: data_w];
    assign lce_req_data_v_o   = data_phase & req_data_v_i[owner];
    assign lce_req_last_o     = lce_req_data_v_o & req_last_i[owner];
    assign grant_o            = owner_one_hot;

    assign req_header_ready_and_o = hdr_phase
                                  ? (owner_one_hot & {num_req_p{lce_req_header_ready_and_i}})
                                  : '0;
    assign req_data_ready_and_o   = data_phase
                                  ? (owner_one_hot & {num_req_p{lce_req_data_ready_and_i}})
                                  : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= e_idle;
            grant_r <= '0;
            rr_ptr  <= '0;
        end else if (msg_done) begin
            state  <= e_idle;
            rr_ptr <= next_ptr;
        end else if (header_hs) begin
            state   <= e_data;
            grant_r <= owner;
        end else if ((state == e_idle) && active) begin
            state   <= e_hdr;
            grant_r <= owner;
        end
    end

    held_header_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state == e_hdr) |-> req_header_v_i[grant_r]);

endmodule
`default_nettype wire
